instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous reset, active-low.
REQ-005 SHALL have port imem_req, output, 1, read request to instruction memory this cycle.
REQ-006 SHALL have port imem_addr, output, 32, byte address of the request, word-aligned.
REQ-007 SHALL have port imem_rdata, input, 32, read data returned exactly one cycle after the request.
REQ-008 SHALL have port redirect, input, 1, pipeline redirect (taken branch, jr/jalr, late jump).
REQ-009 SHALL have port redirect_pc, input, 32, redirect target; bits [1:0] ignored.
REQ-010 SHALL have port id_ready, input, 1, decode stage accepts an instruction this cycle.
REQ-011 SHALL have port if_valid, output, 1, if_instr/if_pc hold a valid instruction.
REQ-012 SHALL have port if_instr, output, 32, instruction word (OpCode = [31:26], Funct = [5:0]).
REQ-013 SHALL have port if_pc, output, 32, address of if_instr.
REQ-014 SHALL have port if_pc4, output, 32, if_pc + 4.

Function
REQ-015 SHALL transfer an instruction when if_valid && id_ready; if_instr/if_pc SHALL be stable while if_valid && !id_ready.
REQ-016 SHALL use states BOOT (first cycle after reset), FETCH (request issued), and HOLD (no credit, no request); BOOT goes to FETCH unconditionally.
REQ-017 SHALL assert imem_req only when occupancy + inflight - pop < 2, where pop = if_valid && id_ready; otherwise the state is HOLD.
REQ-018 SHALL increment the fetch PC by 4 (mod 2^32, wrapping at 32'hFFFF_FFFC to 0) on each issued request.
REQ-019 SHALL push imem_rdata with its PC into the FIFO in the cycle after the request, unless that response has been killed.
REQ-020 On redirect, SHALL clear the FIFO and kill any in-flight response on the same edge, and SHALL issue the next request to {redirect_pc[31:2],2'b00}.
REQ-021 When redirect and a transfer coincide, the transfer SHALL count as completed and the FIFO SHALL still be cleared.
REQ-022 With id_ready held high and no redirects, SHALL sustain one instruction per cycle.
REQ-023 Latency: a request in cycle N SHALL give if_valid in cycle N+2, including the first fetch after reset and the first fetch after a redirect.
REQ-024 If the FIFO is full, SHALL never push; REQ-017 guarantees this, and the bench SHALL check it.

Reset
REQ-025 While reset==0 at the clock edge: state=BOOT, fetch PC=RESET_PC, FIFO empty, inflight=0.
REQ-026 Outputs during reset SHALL be: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=0.
REQ-027 Reset asserted mid-operation SHALL discard in-flight and buffered instructions; no response SHALL be pushed in the cycle after reset.

Configuration
REQ-028 If IF_JUMP_PREDECODE_EN is defined, an accepted response with OpCode 6'h02 (j) or 6'h03 (jal) SHALL be pushed, any younger in-flight response SHALL be killed, and fetch SHALL redirect to {pc4[31:28], instr[25:0], 2'b00}. An external redirect in the same cycle SHALL take priority.
REQ-029 If IF_JUMP_PREDECODE_EN is not defined, j/jal SHALL be treated as ordinary instructions and fetch SHALL continue sequentially.

Structure
REQ-030 SHALL place the OP_J=6'h02 and OP_JAL=6'h03 constants, the fetch state enum, and the FIFO entry struct {pc, instr} in the shared package if_pkg.
REQ-031 SHALL instantiate one sub-module, if_fifo: a 2-entry synchronous FIFO with push, pop, flush, count, and the same clk/reset.

Verification
REQ-032 Reset released, id_ready=1, memory returns addr>>2 -> if_valid first in cycle 2; if_pc = 0, 4, 8, ...; if_instr = 0, 1, 2, ...
REQ-033 id_ready=0 for 5 cycles after the first valid -> imem_req drops once 2 entries are held; if_pc stays 0; no data is lost on release.
REQ-034 redirect=1, redirect_pc=32'h0000_0103 in cycle 6 -> the next imem_addr is 32'h100, the killed response is never presented, and if_pc=32'h100 appears 2 cycles later.
REQ-035 Fetch PC 32'hFFFF_FFFC -> the next imem_addr is 32'h0000_0000.
REQ-036 With IF_JUMP_PREDECODE_EN defined, instr 32'h0800_0040 at pc 32'h10 -> the next if_pc after the jump is 32'h100, and pc 32'h14 is never presented. Without the macro, 32'h14 follows.
REQ-037 Reset pulled low mid-stream with the FIFO full -> if_valid=0 the next cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: opcodes, fetch FSM states and buffer entry type shared by the fetch stage
package if_pkg;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} fetchState_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifEntry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: 2-entry synchronous instruction buffer with flush
import if_pkg::*;
module if_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifEntry_t   wrData,
  output ifEntry_t   rdData,
  output logic [1:0] count
);
  ifEntry_t mem [2];
  logic wrPtr, rdPtr;
  always_ff @(posedge clk)
    if (!reset || flush) begin
      count <= 2'd0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wrData;
        wrPtr <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      count <= count + 2'(push) - 2'(pop);
    end
  always_comb rdData = mem[rdPtr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-based fetch into a 2-entry buffer; IF_JUMP_PREDECODE_EN redirects early on j/jal
import if_pkg::*;
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);
  fetchState_t state, nextState;
  logic [31:0] fetchPc, inflightPc, pc4, jumpPc;
  logic inflight, pop, push, jumpHit, credit;
  logic [1:0] count;
  logic [2:0] occ;
  ifEntry_t head;
  always_comb begin
    if_valid = count != 2'd0;
    pop = if_valid && id_ready;
    push = inflight && !redirect;
    occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    credit = occ < 3'(FIFO_DEPTH);
    pc4 = inflightPc + 32'd4;
    jumpPc = {pc4[31:28], imem_rdata[25:0], 2'b00};
`ifdef IF_JUMP_PREDECODE_EN
    jumpHit = push && (imem_rdata[31:26] == OP_J || imem_rdata[31:26] == OP_JAL);
`else
    jumpHit = 1'b0;
`endif
    // a redirecting cycle never requests, so the younger in-flight slot is empty by construction
    imem_req = reset && !redirect && !jumpHit && (state == BOOT || credit);
    imem_addr = fetchPc;
    nextState = state == BOOT ? FETCH : imem_req ? FETCH : HOLD;
    if_instr = if_valid ? head.instr : 32'd0;
    if_pc = if_valid ? head.pc : 32'd0;
    if_pc4 = if_valid ? head.pc + 32'd4 : 32'd0;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= BOOT;
      fetchPc <= RESET_PC;
      inflight <= 1'b0;
      inflightPc <= RESET_PC;
    end else begin
      state <= nextState;
      inflight <= imem_req;
      if (imem_req) inflightPc <= fetchPc;
      fetchPc <= redirect ? redirect_pc & ~32'h3 : jumpHit ? jumpPc : imem_req ? fetchPc + 32'd4 : fetchPc;
    end
  if_fifo uFifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .wrData('{pc: inflightPc, instr: imem_rdata}),
    .rdData(head),
    .count(count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch against an instruction-stream model
module tb_instr_fetch;
  localparam logic [31:0] RST = 32'h0000_0000;
`ifdef IF_JUMP_PREDECODE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, redirect = 1'b0, id_ready = 1'b1;
  logic [31:0] redirect_pc = 32'd0, imem_rdata = 32'hDEAD_BEEF;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc4;
  int nChecks = 0, nFail = 0;
  bit jumpMode = 1'b0, rstEdge = 1'b0;
  logic [31:0] expPc = RST, prevPc = 0, prevInstr = 0, prevAddr = 0;
  logic prevHold = 0, prevReq = 0, prevRedir = 1, prevJump = 0;
  logic sReq, sValid, sXfer;
  logic [31:0] sAddr, sPc;

  instr_fetch #(.RESET_PC(RST), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc4(if_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (jumpMode && a == 32'h10) ? 32'h0800_0040 : a >> 2;
  endfunction

  function automatic logic isJump(input logic [31:0] i);
    return PRE && (i[31:26] == 6'h02 || i[31:26] == 6'h03);
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem(imem_addr) : 32'hDEAD_BEEF;
    rstEdge <= !reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic check();
    logic [31:0] ins, p4;
    sReq = imem_req; sAddr = imem_addr; sValid = if_valid; sPc = if_pc;
    sXfer = if_valid && id_ready;
    if (!reset) begin
      if (rstEdge) begin
        chkb("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RST);
        chkb("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);
      end
      expPc = RST;
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        chk("hold_pc", if_pc, prevPc);
        chk("hold_instr", if_instr, prevInstr);
      end
      if (imem_req) begin
        chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prevReq && !prevRedir && !prevJump) chk("addr_seq", imem_addr, prevAddr + 32'd4);
      end
      chkb("push_full", dut.uFifo.push && dut.uFifo.count == 2'd2, 1'b0);
      if (sXfer) begin
        ins = mem(expPc);
        p4 = expPc + 32'd4;
        chk("xfer_pc", if_pc, expPc);
        chk("xfer_instr", if_instr, ins);
        chk("xfer_pc4", if_pc4, p4);
        expPc = isJump(ins) ? {p4[31:28], ins[25:0], 2'b00} : p4;
      end
      if (redirect) expPc = redirect_pc & ~32'h3;
      prevHold = if_valid && !id_ready && !redirect;
      prevPc = if_pc;
      prevInstr = if_instr;
    end
    prevReq = reset && imem_req;
    prevAddr = imem_addr;
    prevRedir = redirect || !reset;
    prevJump = isJump(imem_rdata);
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found, done;
    repeat (3) step();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chkb("lat_valid", sValid, k >= 2);
      if (k == 0) begin
        chkb("boot_req", sReq, 1'b1);
        chk("boot_addr", sAddr, RST);
      end
    end
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        chkb("stall_req", sReq, 1'b0);
        chkb("stall_valid", sValid, 1'b1);
      end
    end
    id_ready = 1'b1;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    step();
    chkb("rd_req", sReq, 1'b1);
    chk("rd_addr", sAddr, 32'h100);
    chkb("rd_gap1", sValid, 1'b0);
    step();
    chkb("rd_gap2", sValid, 1'b0);
    step();
    chkb("rd_valid", sValid, 1'b1);
    chk("rd_pc", sPc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    found = 0; done = 0;
    for (int j = 0; j < 10 && !done; j++) begin
      step();
      if (found) begin
        chkb("wrap_req", sReq, 1'b1);
        chk("wrap_addr", sAddr, 32'h0);
        done = 1;
      end else if (sReq && sAddr == 32'hFFFF_FFFC) found = 1;
    end
    chkb("wrap_found", done, 1'b1);
    repeat (6) step();
    jumpMode = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    found = 0; done = 0;
    for (int j = 0; j < 30 && !done; j++) begin
      step();
      if (found && sXfer) begin
        chk("jump_next", sPc, PRE ? 32'h100 : 32'h14);
        done = 1;
      end else if (sXfer && sPc == 32'h10) found = 1;
    end
    chkb("jump_found", done, 1'b1);
    id_ready = 1'b0;
    repeat (4) step();
    chk("full_before_rst", {30'd0, dut.uFifo.count}, 32'd2);
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    id_ready = 1'b1;
    step();
    chkb("rs_valid0", sValid, 1'b0);
    chkb("rs_req", sReq, 1'b1);
    chk("rs_addr", sAddr, RST);
    step();
    chkb("rs_valid1", sValid, 1'b0);
    step();
    chkb("rs_valid2", sValid, 1'b1);
    chk("rs_pc", sPc, RST);
    for (int r = 0; r < 600; r++) begin
      id_ready = $urandom_range(0, 9) < 7;
      redirect = $urandom_range(0, 19) == 0;
      redirect_pc = $urandom;
      reset = $urandom_range(0, 99) != 0;
      step();
    end
    reset = 1'b1; redirect = 1'b0;
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
